// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame/clock settings and
// the mode-0 clock polarity/phase constants also used by spi_slave.
package spi_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 2;
    localparam int DIV_W       = 8;

    // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: tick marks the last cycle of each SCLK half-period and the
// counter reloads on every tick or on an explicit load.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic load,
    output logic tick
);
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: SETUP, DATA_W SCLK pulses, HOLD, FINISH, then a done pulse.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first frames; default is MSB first.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] SETUP  = ST_SETUP;
    localparam logic [2:0] SHIFT  = ST_SHIFT;
    localparam logic [2:0] HOLD   = ST_HOLD;
    localparam logic [2:0] FINISH = ST_FINISH;

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_in;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tx_head;
    logic              accept;
    logic              tick;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_head    = tx_sh[0];
    assign tx_shifted = {1'b0, tx_sh[DATA_W-1:1]};
    assign rx_in      = {miso, rx_sh[DATA_W-1:1]};
`else
    assign tx_head    = tx_sh[DATA_W-1];
    assign tx_shifted = {tx_sh[DATA_W-2:0], 1'b0};
    assign rx_in      = {rx_sh[DATA_W-2:0], miso};
`endif

    // A start coinciding with the done pulse is deliberately not accepted.
    assign accept = (state == IDLE) && start && !done;
    assign mosi   = !ss && tx_head;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .load   (accept),
        .tick   (tick)
    );

    // NOTE: rx_data is a plain output register, so clearing it on reset is cheap and required.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            sclk    <= CPOL;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SETUP;
                        tx_sh   <= tx_data;
                        rx_sh   <= '0;
                        bit_cnt <= '0;
                        ss      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    // End of setup is the first leading edge, so miso is sampled here too.
                    if (tick) begin
                        state <= SHIFT;
                        sclk  <= ~CPOL;
                        rx_sh <= rx_in;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sclk == CPOL) begin
                            sclk  <= ~CPOL;
                            rx_sh <= rx_in;
                        end else begin
                            sclk    <= CPOL;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                            end else begin
                                tx_sh <= tx_shifted;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state <= FINISH;
                        ss    <= 1'b1;
                    end
                end
                FINISH: begin
                    if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sh;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
